hazard_unit: RTL and testbench

- Stall/flush controller for the 5-stage MIPS pipeline; complements the forwarding unit by handling hazards that forwarding cannot resolve.
- Covers load-use, branch-after-load (branch compares in ID), taken-branch/jump squash, and interlocks on a multi-cycle multiply/divide unit.
- Drives PC and IF/ID write enables and the IF/ID and ID/EX flush controls.

---
 rtl/hazard_unit.sv | 104 ++++++++++
 tb/tb_hazard_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use, branch-after-load,
// taken-branch/jump squash and mult/div interlock. Define HAZARD_STATS_EN for stall/flush counters.
module hazard_unit #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IFIDRs,
    input  logic [4:0]  IFIDRt,
    input  logic        IDUseRs,
    input  logic        IDUseRt,
    input  logic        IDBranch,
    input  logic        IDBranchTaken,
    input  logic        IDJump,
    input  logic        IDMulDiv,
    input  logic        IDHiLoRd,
    input  logic        IDEXMemRd,
    input  logic        IDEXRegWr,
    input  logic [4:0]  IDEXRd,
    input  logic        EXMEMMemRd,
    input  logic [4:0]  EXMEMRd,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
`ifdef HAZARD_STATS_EN
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt,
`endif
    output logic        MDBusy
);

    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             ex_match, mem_match;
    logic             load_use, br_load, md_haz;
    logic             stall, redirect;

    // $0 never matches, so a load into $0 cannot create a stall.
    always_comb begin
        ex_match  = (IDEXRd != 5'd0) &&
                    (((IDEXRd == IFIDRs) && IDUseRs) || ((IDEXRd == IFIDRt) && IDUseRt));
        mem_match = (EXMEMRd != 5'd0) &&
                    (((EXMEMRd == IFIDRs) && IDUseRs) || ((EXMEMRd == IFIDRt) && IDUseRt));
    end

    always_comb begin
        load_use = IDEXMemRd && IDEXRegWr && ex_match;
        br_load  = IDBranch && EXMEMMemRd && mem_match;
        md_haz   = (md_cnt_q != '0) && (IDHiLoRd || IDMulDiv);
        stall    = reset && (load_use || br_load || md_haz);
        redirect = reset && !stall && ((IDBranch && IDBranchTaken) || IDJump);
    end

    // Stall wins over the branch/jump squash; the squash happens in the first free cycle.
    always_comb begin
        PCWrite   = !stall;
        IFIDWrite = !stall;
        IDEXFlush = stall;
        IFIDFlush = redirect;
        MDBusy    = reset && (md_cnt_q != '0);
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (IDMulDiv && !stall) begin
            md_cnt_d = CNT_W'(MULDIV_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        flush_cnt_d = flush_cnt_q + {31'd0, redirect};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random traffic against a cycle-time
// reference model; expected outputs go through a queue popped by a negedge monitor.
module tb_hazard_unit;

    localparam int MDC = 4;
`ifdef HAZARD_STATS_EN
    localparam int W = 69;
`else
    localparam int W = 5;
`endif

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       taken;
        logic       jmp;
        logic       md;
        logic       hilo;
        logic       ex_memrd;
        logic       ex_regwr;
        logic [4:0] ex_rd;
        logic       mem_memrd;
        logic [4:0] mem_rd;
    } stim_t;

    logic clk;
    stim_t cur;
    logic PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: cycle count and the cycle at which HI/LO become valid.
    int          cyc = 0;
    int          md_done = 0;
    logic [31:0] m_stalls = 0;
    logic [31:0] m_flushes = 0;
    logic        cur_stall = 0;
    logic        cur_flush = 0;

    hazard_unit #(.MULDIV_CYCLES(MDC), .CNT_W(6)) dut (
        .clk          (clk),
        .reset        (cur.rst_n),
        .IFIDRs       (cur.rs),
        .IFIDRt       (cur.rt),
        .IDUseRs      (cur.use_rs),
        .IDUseRt      (cur.use_rt),
        .IDBranch     (cur.br),
        .IDBranchTaken(cur.taken),
        .IDJump       (cur.jmp),
        .IDMulDiv     (cur.md),
        .IDHiLoRd     (cur.hilo),
        .IDEXMemRd    (cur.ex_memrd),
        .IDEXRegWr    (cur.ex_regwr),
        .IDEXRd       (cur.ex_rd),
        .EXMEMMemRd   (cur.mem_memrd),
        .EXMEMRd      (cur.mem_rd),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IFIDFlush    (IFIDFlush),
        .IDEXFlush    (IDEXFlush),
`ifdef HAZARD_STATS_EN
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt),
`endif
        .MDBusy       (MDBusy)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic logic uses(input stim_t s, input logic [4:0] r);
        return (r != 5'd0) && ((r == s.rs && s.use_rs) || (r == s.rt && s.use_rt));
    endfunction

    // driver: advance the model across the edge, apply new inputs, push the expectation
    task automatic drive(input stim_t s);
        logic busy;
        logic [4:0] e;
        @(posedge clk);
        if (!cur.rst_n) begin
            md_done   = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (cur.md && !cur_stall) md_done = cyc + 1 + MDC;
            m_stalls  = m_stalls + {31'd0, cur_stall};
            m_flushes = m_flushes + {31'd0, cur_flush};
        end
        cyc = cyc + 1;
        #1;
        cur = s;
        busy = s.rst_n && (cyc < md_done);
        cur_stall = s.rst_n && ((s.ex_memrd && s.ex_regwr && uses(s, s.ex_rd)) ||
                                (s.br && s.mem_memrd && uses(s, s.mem_rd)) ||
                                (busy && (s.hilo || s.md)));
        cur_flush = s.rst_n && !cur_stall && ((s.br && s.taken) || s.jmp);
        if (!s.rst_n)       e = 5'b11000;
        else if (cur_stall) e = {4'b0001, busy};
        else if (cur_flush) e = {4'b1110, busy};
        else                e = {4'b1100, busy};
`ifdef HAZARD_STATS_EN
        exp_q.push_back({e, m_stalls, m_flushes});
`else
        exp_q.push_back(e);
`endif
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] got, exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
`ifdef HAZARD_STATS_EN
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy, StallCnt, FlushCnt};
`else
            got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MDBusy};
`endif
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL outputs cycle %0d: got %h expected %h (PC,IFIDW,IFIDFl,IDEXFl,MDBusy[,stall,flush])",
                         cyc, got, exp_v);
            end
        end
    end

    initial begin
        stim_t s;
        cur = '0;
        repeat (2) drive('0);

        // load-use then no stall with load in MEM
        s = idle(); s.ex_memrd = 1; s.ex_regwr = 1; s.ex_rd = 8; s.rs = 8; s.use_rs = 1;
        drive(s);
        s = idle(); s.mem_memrd = 1; s.mem_rd = 8; s.rs = 8; s.use_rs = 1;
        drive(s);

        // branch after load: loadUse, brLoad, then taken branch flushes
        s = idle(); s.ex_memrd = 1; s.ex_regwr = 1; s.ex_rd = 9; s.rt = 9; s.use_rt = 1; s.br = 1;
        drive(s);
        s = idle(); s.mem_memrd = 1; s.mem_rd = 9; s.rt = 9; s.use_rt = 1; s.br = 1;
        drive(s);
        s = idle(); s.rt = 9; s.use_rt = 1; s.br = 1; s.taken = 1;
        drive(s);

        // $0 immunity
        s = idle(); s.ex_memrd = 1; s.ex_regwr = 1; s.ex_rd = 0; s.rs = 0; s.use_rs = 1;
        drive(s);

        // mult followed by mflo
        s = idle(); s.md = 1;
        drive(s);
        s = idle(); s.hilo = 1;
        repeat (MDC + 1) drive(s);
        drive(idle());

        // taken branch while EX load targets its rs, then resolved
        s = idle(); s.br = 1; s.taken = 1; s.rs = 5; s.use_rs = 1;
        s.ex_memrd = 1; s.ex_regwr = 1; s.ex_rd = 5;
        drive(s);
        s.ex_memrd = 0; s.ex_regwr = 0; s.ex_rd = 0;
        drive(s);

        // reset mid-mult at mdCnt=3
        s = idle(); s.md = 1;
        drive(s);
        drive(idle());
        s = idle(); s.rst_n = 0;
        drive(s);
        s = idle(); s.hilo = 1;
        drive(s);

        // random traffic with a narrow register set to provoke hazards
        for (int i = 0; i < 2000; i++) begin
            s = '0;
            s.rst_n     = ($urandom_range(0, 60) != 0);
            s.rs        = 5'($urandom_range(0, 3));
            s.rt        = 5'($urandom_range(0, 3));
            s.use_rs    = 1'($urandom_range(0, 1));
            s.use_rt    = 1'($urandom_range(0, 1));
            s.br        = ($urandom_range(0, 3) == 0);
            s.taken     = 1'($urandom_range(0, 1));
            s.jmp       = ($urandom_range(0, 7) == 0);
            s.md        = ($urandom_range(0, 5) == 0);
            s.hilo      = ($urandom_range(0, 3) == 0);
            s.ex_memrd  = 1'($urandom_range(0, 1));
            s.ex_regwr  = 1'($urandom_range(0, 1));
            s.ex_rd     = 5'($urandom_range(0, 3));
            s.mem_memrd = 1'($urandom_range(0, 1));
            s.mem_rd    = 5'($urandom_range(0, 3));
            drive(s);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
